// File: rtl/dmem_line_responder_pkg.sv
// Shared types and constants for the data-memory line responder.
// Imported by the interface, the storage array and the top level.
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Line-index width for a given number of lines (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_line_responder_if.sv
// Cache miss/write-back port between the data cache (master) and the line responder (slave).
// Handshake: the master raises mem_enable_i with write/addr/data and holds enable until it samples
// mem_ack_o; the slave latches the request on the first idle edge and answers with a one-cycle ack.
interface dmem_line_responder_if;
  import dmem_pkg::*;

  logic              mem_enable_i;
  logic              mem_write_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [LINE_W-1:0] mem_data_i;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_o;

  modport slave (
    input  mem_enable_i,
    input  mem_write_i,
    input  mem_addr_i,
    input  mem_data_i,
    output mem_data_o,
    output mem_ack_o
  );

  modport master (
    output mem_enable_i,
    output mem_write_i,
    output mem_addr_i,
    output mem_data_i,
    input  mem_data_o,
    input  mem_ack_o
  );

endinterface

// File: rtl/dmem_line_responder_array.sv
// DEPTH x LINE_W line storage: one synchronous write port, one synchronous read port.
// The read register only updates on a read, so it holds the last fill between accesses.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [LINE_W-1:0] r_rdata;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_ridx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_line_responder.sv
// Line-granular data memory behind the data-cache miss port: one fill or write-back at a time,
// completed after LATENCY cycles with a single-cycle acknowledge.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  dmem_line_responder_if.slave        bus,
  input  logic                        i_pre_we,
  input  logic [idx_width(DEPTH)-1:0] i_pre_idx,
  input  logic [LINE_W-1:0]           i_pre_data,
  output state_t                      o_state
);

  localparam int         IDX_W    = idx_width(DEPTH);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_ack;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;

  logic              w_access;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_arr_we;
  logic [IDX_W-1:0]  w_arr_widx;
  logic [LINE_W-1:0] w_arr_wdata;
  logic [IDX_W-1:0]  w_req_idx;
  logic              w_unused;

  // Offset bits and bits above the index only alias; they never select storage.
  assign w_req_idx = bus.mem_addr_i[OFFSET_W +: IDX_W];
  assign w_unused  = ^{bus.mem_addr_i[ADDR_W-1:OFFSET_W+IDX_W], bus.mem_addr_i[OFFSET_W-1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_enable_i) begin
            r_write <= bus.mem_write_i;
            r_idx   <= w_req_idx;
            r_wdata <= bus.mem_data_i;
            r_cnt   <= CNT_INIT;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_ack   <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        // The initiator reacts to the ack on this edge, so the request lines are ignored here.
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_access = (r_state == ST_BUSY) && (r_cnt == 8'd0);
  assign w_rd_en  = w_access && !r_write;
  assign w_wr_en  = w_access &&  r_write;

  // Preload wins the write port; it is only used while the responder is idle.
  assign w_arr_we    = i_pre_we | w_wr_en;
  assign w_arr_widx  = i_pre_we ? i_pre_idx  : r_idx;
  assign w_arr_wdata = i_pre_we ? i_pre_data : r_wdata;

  dmem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_arr_we),
    .i_widx  (w_arr_widx),
    .i_wdata (w_arr_wdata),
    .i_re    (w_rd_en),
    .i_ridx  (r_idx),
    .o_rdata (bus.mem_data_o)
  );

  assign bus.mem_ack_o = r_ack;
  assign o_state       = r_state;

endmodule
